// File: rtl/mmio_io_responder_pkg.sv
// IO window map and register-select decode shared by the MMIO responder and its debouncer.
// Pure constants and a combinational decode helper; no latency, no backpressure.
package mmio_io_responder_pkg;

  localparam logic [15:0] IO_MEM       = 16'hCFFD;
  localparam logic [15:0] SWITCHES_LOC = 16'hCFFD;
  localparam logic [15:0] LEDS_LOC     = 16'hCFFE;
  localparam logic [15:0] STATUS_LOC   = 16'hCFFF;

  typedef enum logic [1:0] {
    REG_NONE,
    REG_SWITCHES,
    REG_LEDS,
    REG_STATUS
  } io_sel_e;

  function automatic io_sel_e io_decode(input logic [15:0] addr);
    case (addr)
      SWITCHES_LOC: io_decode = REG_SWITCHES;
      LEDS_LOC:     io_decode = REG_LEDS;
      STATUS_LOC:   io_decode = REG_STATUS;
      default:      io_decode = REG_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mmio_io_responder_if.sv
// CPU port-A bus as seen by the IO responder; rdata/io_hit arrive one cycle after address.
// No backpressure: the responder accepts every access.
interface mmio_io_responder_if;
  logic [15:0] address;
  logic [15:0] wdata;
  logic        wren;
  logic        ram_wren;
  logic        io_hit;
  logic [15:0] rdata;

  modport master (output address, wdata, wren, input ram_wren, io_hit, rdata);
  modport slave  (input address, wdata, wren, output ram_wren, io_hit, rdata);
endinterface

// File: rtl/mmio_io_responder_switch_debouncer.sv
// Two-flop synchronizer plus hold-counter debouncer; stable value lags raw by 2+DEBOUNCE_CYCLES clocks.
// No backpressure; sw_update is a one-cycle combinational pulse on the edge sw_stable changes.
module mmio_io_responder_switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_WIDTH        = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SW_WIDTH-1:0] switches_raw,
  output logic [SW_WIDTH-1:0] sw_stable,
  output logic                sw_update
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SW_WIDTH-1:0] sync_q1;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [CNT_W-1:0]    cnt;

  // Updates only fire while sync differs from stable, so every update is a real change.
  assign sw_update = (sw_sync != sw_stable) && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q1   <= '0;
      sw_sync   <= '0;
      sw_stable <= '0;
      cnt       <= '0;
    end else begin
      sync_q1 <= switches_raw;
      sw_sync <= sync_q1;
      if (sw_sync == sw_stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        sw_stable <= sw_sync;
        cnt       <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/mmio_io_responder.sv
// IO-window responder at 0xCFFD+: registered read data 1 cycle after address, LEDS latch, switch status.
// No backpressure; IO writes are masked from EXRAM via ram_wren.
module mmio_io_responder
  import mmio_io_responder_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_WIDTH        = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  mmio_io_responder_if.slave   bus,
  input  logic [SW_WIDTH-1:0]  switches_raw,
  output logic [15:0]          seg_value
);

  logic [SW_WIDTH-1:0] sw_stable;
  logic                sw_update;
  logic                sw_changed;
  logic                status_rd;
  logic [15:0]         rd_mux;
  io_sel_e             sel;

  mmio_io_responder_switch_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .SW_WIDTH        (SW_WIDTH)
  ) u_debounce (
    .clk          (clk),
    .reset        (reset),
    .switches_raw (switches_raw),
    .sw_stable    (sw_stable),
    .sw_update    (sw_update)
  );

  assign sel          = io_decode(bus.address);
  assign bus.ram_wren = bus.wren & (bus.address < IO_MEM);
  assign status_rd    = !bus.wren && (sel == REG_STATUS);

  always_comb begin
    rd_mux = 16'h0000;
    case (sel)
      REG_SWITCHES: rd_mux = 16'(sw_stable);
      REG_LEDS:     rd_mux = seg_value;
      REG_STATUS:   rd_mux = {15'b0, sw_changed};
      default:      rd_mux = 16'h0000;
    endcase
  end

  // rd_mux samples pre-edge state, giving read-before-write on LEDS and pre-clear STATUS.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_value  <= 16'h0000;
      sw_changed <= 1'b0;
      bus.rdata  <= 16'h0000;
      bus.io_hit <= 1'b0;
    end else begin
      if (bus.wren && sel == REG_LEDS)
        seg_value <= bus.wdata;
      sw_changed <= sw_update | (sw_changed & ~status_rd);
      bus.rdata  <= rd_mux;
      bus.io_hit <= (bus.address >= IO_MEM);
    end
  end

endmodule
